btn_press_detect: RTL and testbench
===================================

// Module: btn_press_detect
// PURPOSE
//   Conditions a raw mechanical push-button into clean, single-cycle press
//   events for the LED blink stage downstream, e.g. short press = next blink
//   rate, long press = blink on/off. Synchronises the asynchronous pin,
//   debounces it, and classifies each press as short or long. Exactly one
//   event is produced per physical press.
// PARAMETERS
//   DEBOUNCE_CYCLES    1000   consecutive stable cycles before level is accepted (>=1)
//   LONG_PRESS_CYCLES  20000  debounced-hold cycles that make a press "long" (>=2)
// PORTS
//   clk          in   1  system clock; all logic on posedge
//   rst          in   1  asynchronous, active-high reset
//   btn_in       in   1  raw button pin, asynchronous to clk, 1 = pressed
//   btn_level    out  1  debounced, synchronised button level
//   held         out  1  1 while a press is in progress (PRESSED or LONG state)
//   short_press  out  1  one-cycle pulse on release of a press shorter than LONG_PRESS_CYCLES
//   long_press   out  1  one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
// BEHAVIOUR
//   Reset (async assert, sync-released use): sync flops, btn_level, held,
//     short_press, long_press, all counters = 0; FSM = IDLE.
//   Synchroniser: 2-flop chain, btn_in -> s0 -> s1. s1 is the only consumer of btn_in.
//   Debounce:
//     - deb_cnt counts cycles with s1 != btn_level; any cycle with s1 == btn_level clears it.
//     - When deb_cnt == DEBOUNCE_CYCLES-1 and s1 != btn_level: btn_level <= s1, deb_cnt <= 0.
//     - Latency: btn_in edge to btn_level edge = 2 + DEBOUNCE_CYCLES cycles (clean edge).
//     - Glitches shorter than DEBOUNCE_CYCLES never reach btn_level.
//     - Width: $clog2(DEBOUNCE_CYCLES+1); counter never wraps.
//   Press FSM (evaluated on btn_level, registered outputs):
//     IDLE    : btn_level==1 -> PRESSED, hold_cnt <= 0.
//     PRESSED : btn_level==0 -> short_press pulse, -> IDLE  (release has priority).
//               else if hold_cnt == LONG_PRESS_CYCLES-1 -> long_press pulse, -> LONG.
//               else hold_cnt <= hold_cnt + 1.
//     LONG    : btn_level==0 -> IDLE, no pulse; hold_cnt frozen (no wrap).
//   - held = 1 in PRESSED and LONG, registered with the state (asserts the
//     cycle after btn_level rises).
//   - Pulses: high exactly one cycle; short_press and long_press never both in one press.
//   - Release in the cycle hold_cnt hits threshold -> short_press (release wins).
//   - Reset mid-press: outputs drop immediately, no pulse emitted. A button
//     still held after reset is re-detected as a new press after 2+DEBOUNCE_CYCLES cycles.
//   - hold_cnt width $clog2(LONG_PRESS_CYCLES); saturating by construction.
// STRUCTURE
//   - btn_pkg.vh: FSM encodings ST_IDLE=2'd0, ST_PRESSED=2'd1, ST_LONG=2'd2;
//     shared with the blink-mode controller for debug/status readout.
//   - Sub-module sync_2ff (clk, rst, d, q): reusable 2-flop synchroniser,
//     reset value 0.
//   - Remainder in one module: debounce counter + press FSM.
//   - Elaboration check: $error if DEBOUNCE_CYCLES<1 or LONG_PRESS_CYCLES<2.
// TESTING  (bench params DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
//   1 clean press: btn_in 0->1 at cycle 10, held 10 cycles, then 0
//     -> btn_level rises at cycle 16; one short_press pulse after fall; long_press never.
//   2 bounce: btn_in toggles every 2 cycles for 12 cycles, then stays 1
//     -> btn_level rises exactly once, 6 cycles after final edge; no intermediate transitions.
//   3 long press: btn_in=1 for 40 cycles
//     -> long_press pulses once, 16 cycles after held rises; held stays 1 until
//        release; no short_press on release.
//   4 boundary: release timed so btn_level falls in the cycle hold_cnt==15
//     -> short_press only; then hold one cycle longer -> long_press only.
//   5 reset mid-press: assert rst during PRESSED, btn_in kept 1
//     -> all outputs 0 within the reset cycle, no pulse; after release of rst,
//        btn_level re-rises after 6 cycles and a new press is tracked.
//   6 glitch reject: 3-cycle 1-pulse on btn_in from idle -> btn_level, held, pulses all stay 0.

Source files
------------

// File: rtl/btn_press_detect_pkg.sv
// btn_press_detect_pkg: press FSM encodings shared with the blink-mode controller for status readout
package btn_press_detect_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_t;
endpackage

// File: rtl/btn_press_detect_sync_2ff.sv
// btn_press_detect_sync_2ff: two-flop synchroniser for an asynchronous level
//   clk  in  system clock
//   rst  in  asynchronous active-high reset, output resets to 0
//   d    in  asynchronous input
//   q    out d synchronised to clk, two cycles of latency
module btn_press_detect_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s0;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s0} <= 2'b00;
    else {q, s0} <= {s0, d};
endmodule

// File: rtl/btn_press_detect.sv
// btn_press_detect: synchronise, debounce and classify a push-button into short/long press pulses
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   btn_in       in   raw button pin, asynchronous, 1 = pressed
//   btn_level    out  debounced, synchronised button level
//   held         out  1 while a press is in progress
//   short_press  out  one-cycle pulse on release of a press shorter than LONG_PRESS_CYCLES
//   long_press   out  one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
module btn_press_detect
  import btn_press_detect_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int LONG_PRESS_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic held,
  output logic short_press,
  output logic long_press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_PRESS_CYCLES);
  if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 2) begin : g_param_check
    $error("btn_press_detect: need DEBOUNCE_CYCLES >= 1 and LONG_PRESS_CYCLES >= 2");
  end
  logic s1;
  logic [DW-1:0] deb_cnt;
  logic [HW-1:0] hold_cnt;
  btn_state_t state;
  btn_press_detect_sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_in),
    .q  (s1)
  );
  // deb_cnt measures how long s1 has disagreed with the accepted level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      deb_cnt   <= '0;
      btn_level <= 1'b0;
    end else if (s1 == btn_level) deb_cnt <= '0;
    else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_level <= s1;
      deb_cnt   <= '0;
    end else deb_cnt <= deb_cnt + DW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      held        <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      case (state)
        ST_IDLE:
          if (btn_level) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
            held     <= 1'b1;
          end
        // release is tested first so it wins over reaching the long threshold
        ST_PRESSED:
          if (!btn_level) begin
            short_press <= 1'b1;
            state       <= ST_IDLE;
            held        <= 1'b0;
          end else if (hold_cnt == HW'(LONG_PRESS_CYCLES - 1)) begin
            long_press <= 1'b1;
            state      <= ST_LONG;
          end else hold_cnt <= hold_cnt + HW'(1);
        ST_LONG:
          if (!btn_level) begin
            state <= ST_IDLE;
            held  <= 1'b0;
          end
        default: begin
          state <= ST_IDLE;
          held  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_btn_press_detect.sv
// tb_btn_press_detect: directed scenarios plus random button activity against a timeline model
module tb_btn_press_detect;
  localparam int D = 4;
  localparam int L = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, held, short_press, long_press;
  int errors = 0;
  int checks = 0;
  btn_press_detect #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .held       (held),
    .short_press(short_press),
    .long_press (long_press)
  );
  always #5 clk = ~clk;
  // reference: the pin seen two cycles late, a level that flips after D
  // consecutive disagreeing cycles, and presses classified by timestamps
  bit dly[$];
  bit lvl, mh, ms, ml, long_done, prev_level;
  int streak, cyc, rise_at;
  int n_short, n_long, n_rise;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask
  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    dly = '{1'b0, 1'b0};
    lvl = 0; mh = 0; ms = 0; ml = 0; long_done = 0; streak = 0;
  endtask
  task automatic step(input logic b, input logic r);
    bit s1, lv0;
    @(negedge clk);
    btn_in = b;
    rst = r;
    if (r) begin
      #1;
      chk("rst_btn_level", btn_level, 1'b0);
      chk("rst_held", held, 1'b0);
      chk("rst_short", short_press, 1'b0);
      chk("rst_long", long_press, 1'b0);
    end
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else begin
      s1 = dly[0];
      lv0 = lvl;
      dly.pop_front();
      dly.push_back(b);
      ms = 0;
      ml = 0;
      if (s1 != lvl) begin
        streak++;
        if (streak == D) begin
          lvl = s1;
          streak = 0;
        end
      end else streak = 0;
      if (!mh) begin
        if (lv0) begin
          mh = 1;
          rise_at = cyc;
          long_done = 0;
        end
      end else if (!lv0) begin
        ms = !long_done;
        mh = 0;
      end else if (!long_done && cyc - rise_at == L) begin
        ml = 1;
        long_done = 1;
      end
    end
    #1;
    chk("btn_level", btn_level, lvl);
    chk("held", held, mh);
    chk("short_press", short_press, ms);
    chk("long_press", long_press, ml);
    n_short += int'(short_press);
    n_long += int'(long_press);
    n_rise += int'(btn_level && !prev_level);
    prev_level = btn_level;
  endtask
  task automatic run(input logic b, input int n);
    repeat (n) step(b, 1'b0);
  endtask
  task automatic scen(input string tag, input int r0, input int s0, input int l0,
                      input int er, input int es, input int el);
    chkn({tag, "_rises"}, n_rise - r0, er);
    chkn({tag, "_shorts"}, n_short - s0, es);
    chkn({tag, "_longs"}, n_long - l0, el);
  endtask
  initial begin
    int r0, s0, l0;
    model_reset();
    cyc = 0; n_short = 0; n_long = 0; n_rise = 0; prev_level = 0;
    repeat (3) step(1'b0, 1'b1);
    run(1'b0, 6);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, 10);
    run(1'b0, 20);
    scen("clean", r0, s0, l0, 1, 1, 0);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    repeat (3) begin
      run(1'b1, 2);
      run(1'b0, 2);
    end
    run(1'b1, 14);
    run(1'b0, 20);
    scen("bounce", r0, s0, l0, 1, 1, 0);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, 40);
    run(1'b0, 20);
    scen("long", r0, s0, l0, 1, 0, 1);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, L);
    run(1'b0, 20);
    scen("edge_short", r0, s0, l0, 1, 1, 0);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, L + 1);
    run(1'b0, 20);
    scen("edge_long", r0, s0, l0, 1, 0, 1);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, 12);
    repeat (3) step(1'b1, 1'b1);
    run(1'b1, 12);
    run(1'b0, 20);
    scen("reset_mid", r0, s0, l0, 2, 1, 0);
    r0 = n_rise; s0 = n_short; l0 = n_long;
    run(1'b1, 3);
    run(1'b0, 20);
    scen("glitch", r0, s0, l0, 0, 0, 0);
    repeat (200) run(1'($urandom_range(0, 1)), int'($urandom_range(1, 25)));
    run(1'b0, 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
